// File: rtl/huff_codebook_header_if.sv
// Memory read port and serial header stream of the Huffman codebook header walker.
interface huff_codebook_header_if;
    logic [70:0] h_element;
    logic [6:0]  curr_index;
    logic        SRAM_enable;
    logic        wait_cycle;
    logic        bit1;
    logic        enable;
    logic        write_finish;
    logic [8:0]  header;

    modport master (
        input  h_element,
        output curr_index, SRAM_enable, wait_cycle, bit1, enable, write_finish, header
    );
    modport slave (
        output h_element,
        input  curr_index, SRAM_enable, wait_cycle, bit1, enable, write_finish, header
    );
endinterface

// File: rtl/huff_codebook_header.sv
// Depth-first Huffman tree walker emitting each leaf char and its code, with a bit-serial header writer.
// Optional feature macro: CB_WAIT_CYCLE_EN inserts one bubble cycle after every node address load.
module huff_codebook_header (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    max_index,
    huff_codebook_header_if.master        bus,
    output logic [2:0]                    curr_state,
    output logic [127:0]                  curr_path,
    output logic [127:0]                  char_path,
    output logic [7:0]                    char_index,
    output logic                          char_found,
    output logic [6:0]                    track_length,
    output logic [6:0]                    pos,
    output logic [8:0]                    least1,
    output logic [8:0]                    least2,
    output logic [3:0]                    finished
);
    typedef enum logic [2:0] {
        LEFT = 3'd0, RIGHT = 3'd1, TRACK = 3'd2, BACKTRACK = 3'd3,
        FINISH = 3'd4, INIT = 3'd5, SEND = 3'd6
    } state_t;

`ifdef CB_WAIT_CYCLE_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    state_t     state_reg, ret_reg;
    logic       back_bit_reg;
    logic [7:0] ser_cnt_reg;
    logic       wait_reg;
    logic [8:0] left_c, right_c;
    logic [6:0] trk_idx, step_idx, code_idx;
    logic [7:0] ser_total;
    logic       ser_bit;
    wire        unused_bits = ^{bus.h_element[70:64], bus.h_element[45:0]};

    function automatic logic is_null(input logic [8:0] c);
        return c[8:7] == 2'b11;
    endfunction

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v == 7'h7f) ? v : v + 7'd1;
    endfunction

    assign left_c      = bus.h_element[63:55];
    assign right_c     = bus.h_element[54:46];
    assign curr_state  = state_reg;
    assign bus.SRAM_enable = (state_reg == LEFT) || (state_reg == RIGHT) || (state_reg == TRACK);
    assign bus.wait_cycle  = wait_reg;

    // TRACK replays the stored path from the root, oldest (MSB) step first.
    assign trk_idx  = track_length - 7'd1 - pos;
    assign step_idx = curr_path[trk_idx] ? right_c[6:0] : left_c[6:0];

    // Serial header: 8 char bits, then track_length code bits oldest first.
    assign ser_total = {1'b0, track_length} + 8'd8;
    assign code_idx  = track_length - 7'd1 - (ser_cnt_reg[6:0] - 7'd8);
    assign ser_bit   = (ser_cnt_reg < 8'd8) ? char_index[3'd7 - ser_cnt_reg[2:0]]
                                            : char_path[code_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= INIT;
            ret_reg          <= LEFT;
            back_bit_reg     <= 1'b0;
            ser_cnt_reg      <= 8'd0;
            wait_reg         <= 1'b0;
            bus.curr_index   <= 7'd0;
            bus.bit1         <= 1'b0;
            bus.enable       <= 1'b0;
            bus.write_finish <= 1'b0;
            bus.header       <= 9'd0;
            curr_path        <= 128'd0;
            char_path        <= 128'd0;
            char_index       <= 8'd0;
            char_found       <= 1'b0;
            track_length     <= 7'd0;
            pos              <= 7'd0;
            least1           <= 9'd0;
            least2           <= 9'd0;
            finished         <= 4'd0;
        end else if (wait_reg) begin
            wait_reg <= 1'b0;
        end else begin
            bus.write_finish <= 1'b0;
            case (state_reg)
                INIT: begin
                    bus.curr_index <= max_index;
                    curr_path      <= 128'd0;
                    track_length   <= 7'd0;
                    wait_reg       <= WAIT_EN;
                    state_reg      <= LEFT;
                end
                LEFT: begin
                    least1 <= left_c;
                    least2 <= right_c;
                    if (is_null(left_c)) begin
                        state_reg <= RIGHT;
                    end else if (!left_c[8]) begin
                        char_index   <= left_c[7:0];
                        bus.header   <= {1'b1, left_c[7:0]};
                        char_path    <= {curr_path[126:0], 1'b0};
                        track_length <= sat_inc(track_length);
                        char_found   <= 1'b1;
                        ser_cnt_reg  <= 8'd0;
                        ret_reg      <= RIGHT;
                        state_reg    <= SEND;
                    end else begin
                        curr_path      <= {curr_path[126:0], 1'b0};
                        track_length   <= sat_inc(track_length);
                        bus.curr_index <= left_c[6:0];
                        wait_reg       <= WAIT_EN;
                    end
                end
                RIGHT: begin
                    least1 <= left_c;
                    least2 <= right_c;
                    if (is_null(right_c)) begin
                        state_reg <= BACKTRACK;
                    end else if (!right_c[8]) begin
                        char_index   <= right_c[7:0];
                        bus.header   <= {1'b1, right_c[7:0]};
                        char_path    <= {curr_path[126:0], 1'b1};
                        track_length <= sat_inc(track_length);
                        char_found   <= 1'b1;
                        ser_cnt_reg  <= 8'd0;
                        ret_reg      <= BACKTRACK;
                        state_reg    <= SEND;
                    end else begin
                        curr_path      <= {curr_path[126:0], 1'b1};
                        track_length   <= sat_inc(track_length);
                        bus.curr_index <= right_c[6:0];
                        wait_reg       <= WAIT_EN;
                        state_reg      <= LEFT;
                    end
                end
                SEND: begin
                    if (bus.write_finish) begin
                        char_found <= 1'b0;
                        if (track_length != 7'd0)
                            track_length <= track_length - 7'd1;
                        state_reg <= ret_reg;
                    end else if (ser_cnt_reg < ser_total) begin
                        bus.bit1    <= ser_bit;
                        bus.enable  <= 1'b1;
                        ser_cnt_reg <= ser_cnt_reg + 8'd1;
                    end else begin
                        bus.bit1         <= 1'b0;
                        bus.enable       <= 1'b0;
                        bus.write_finish <= 1'b1;
                    end
                end
                BACKTRACK: begin
                    if (track_length == 7'd0) begin
                        finished  <= 4'b0101;
                        state_reg <= FINISH;
                    end else begin
                        back_bit_reg   <= curr_path[0];
                        curr_path      <= curr_path >> 1;
                        track_length   <= track_length - 7'd1;
                        bus.curr_index <= max_index;
                        pos            <= 7'd0;
                        wait_reg       <= WAIT_EN;
                        state_reg      <= TRACK;
                    end
                end
                TRACK: begin
                    least1 <= left_c;
                    least2 <= right_c;
                    if (pos == track_length) begin
                        state_reg <= back_bit_reg ? BACKTRACK : RIGHT;
                    end else begin
                        bus.curr_index <= step_idx;
                        pos            <= pos + 7'd1;
                        wait_reg       <= WAIT_EN;
                    end
                end
                FINISH: begin
                    finished <= 4'b0101;
                end
                default: state_reg <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_codebook_header.sv
// Self-checking bench: fixed trees from a vector table, chain and random trees against a DFS model.
`timescale 1ns/1ps
module tb_huff_codebook_header;
    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   max_index;
    logic [2:0]   curr_state;
    logic [127:0] curr_path, char_path;
    logic [7:0]   char_index;
    logic         char_found;
    logic [6:0]   track_length, pos;
    logic [8:0]   least1, least2;
    logic [3:0]   finished;

    huff_codebook_header_if bus();

    huff_codebook_header dut (
        .clk(clk), .rst(rst), .max_index(max_index), .bus(bus),
        .curr_state(curr_state), .curr_path(curr_path), .char_path(char_path),
        .char_index(char_index), .char_found(char_found), .track_length(track_length),
        .pos(pos), .least1(least1), .least2(least2), .finished(finished)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] NUL = 9'h180;
    logic [70:0] mem [0:127];
    assign bus.h_element = mem[bus.curr_index];

    typedef struct { logic [7:0] ch; logic [127:0] path; int len; } emit_t;
    typedef struct { int tree; logic [7:0] ch; logic [127:0] path; int len; } vec_t;
    typedef struct { logic [8:0] c; logic [127:0] path; int len; } work_t;

    emit_t exp_q[$];
    vec_t  tbl[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;

    task automatic check(input string nm, input logic [135:0] act, input logic [135:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    endtask

    function automatic logic [70:0] mk_node(input logic [8:0] l, input logic [8:0] r);
        return {7'h2a, l, r, 46'h155};
    endfunction

    function automatic logic [8:0] lf(input int c);
        return {1'b0, 8'(c)};
    endfunction

    function automatic logic [8:0] in(input int i);
        return {2'b10, 7'(i)};
    endfunction

    task automatic add_vec(input int t, input int c, input int p, input int l);
        vec_t v;
        v.tree = t; v.ch = 8'(c); v.path = 128'(p); v.len = l;
        tbl.push_back(v);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = mk_node(NUL, NUL);
    endtask

    task automatic load_fixed(input int t, output logic [6:0] root);
        clear_mem();
        case (t)
            0: begin mem[0] = mk_node(lf(67), NUL); root = 7'd0; end
            1: begin
                mem[8] = mk_node(in(7), in(6));  mem[7] = mk_node(in(5), in(4));
                mem[5] = mk_node(in(3), in(2));  mem[3] = mk_node(lf(67), lf(66));
                mem[2] = mk_node(lf(68), lf(69)); mem[4] = mk_node(in(1), in(0));
                mem[1] = mk_node(lf(72), lf(73)); mem[0] = mk_node(lf(65), lf(70));
                mem[6] = mk_node(lf(71), lf(74)); root = 7'd8;
            end
            default: begin
                mem[2] = mk_node(in(1), NUL); mem[1] = mk_node(lf(88), in(0));
                mem[0] = mk_node(lf(89), lf(65)); root = 7'd2;
            end
        endcase
    endtask

    task automatic load_chain(output logic [6:0] root);
        clear_mem();
        mem[0] = mk_node(lf(200), lf(201));
        for (int i = 1; i < 30; i++) mem[i] = mk_node(in(i - 1), lf(100 + i));
        root = 7'd29;
    endtask

    task automatic load_random(output logic [6:0] root);
        logic [8:0] pool[$];
        logic [8:0] a, b;
        int nl, k, unary, ai;
        clear_mem();
        nl = $urandom_range(2, 16); k = 0; unary = 0;
        for (int i = 0; i < nl; i++) pool.push_back({1'b0, 8'($urandom_range(0, 255))});
        while (pool.size() > 1) begin
            ai = $urandom_range(0, pool.size() - 1); a = pool[ai]; pool.delete(ai);
            if (unary < 4 && $urandom_range(0, 5) == 0) begin
                mem[k] = mk_node(a, NUL); unary++;
            end else begin
                ai = $urandom_range(0, pool.size() - 1); b = pool[ai]; pool.delete(ai);
                mem[k] = mk_node(a, b);
            end
            pool.push_back(in(k));
            k++;
        end
        root = 7'(k - 1);
    endtask

    // Reference: explicit-stack preorder traversal, left before right, nulls skipped.
    task automatic model_walk(input logic [6:0] root);
        work_t stk[$];
        work_t w, nw;
        emit_t e;
        logic [70:0] n;
        exp_q.delete();
        w.c = in(int'(root)); w.path = '0; w.len = 0;
        stk.push_back(w);
        while (stk.size() > 0) begin
            w = stk.pop_back();
            if (!w.c[8]) begin
                e.ch = w.c[7:0]; e.path = w.path; e.len = w.len;
                exp_q.push_back(e);
            end else begin
                n = mem[w.c[6:0]];
                if (n[54:53] != 2'b11) begin
                    nw.c = n[54:46]; nw.path = (w.path << 1) | 128'd1; nw.len = w.len + 1;
                    stk.push_back(nw);
                end
                if (n[63:62] != 2'b11) begin
                    nw.c = n[63:55]; nw.path = w.path << 1; nw.len = w.len + 1;
                    stk.push_back(nw);
                end
            end
        end
    endtask

    task automatic table_expect(input int t);
        emit_t e;
        exp_q.delete();
        foreach (tbl[i]) if (tbl[i].tree == t) begin
            e.ch = tbl[i].ch; e.path = tbl[i].path; e.len = tbl[i].len;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset(input string nm);
        check({nm, "/state"}, 136'(curr_state), 136'd5);
        check({nm, "/curr_path"}, 136'(curr_path), 136'd0);
        check({nm, "/char_path"}, 136'(char_path), 136'd0);
        check({nm, "/misc"}, 136'({bus.curr_index, char_index, char_found, track_length, pos,
              least1, least2, finished, bus.SRAM_enable, bus.wait_cycle, bus.write_finish,
              bus.bit1, bus.enable, bus.header}), 136'd0);
    endtask

    task automatic run_walk(input string nm, input logic [6:0] root, input bit do_reset);
        int got, ser_n, max_len, exp_max;
        bit done, wait_bad;
        logic [135:0] ser_w, ew;
        logic [6:0] prev_idx;
        emit_t e;
        max_index = root;
        if (do_reset) begin
            rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        end
        got = 0; ser_n = 0; ser_w = '0; max_len = 0; done = 0; wait_bad = 0;
        prev_idx = bus.curr_index;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (bus.enable) begin ser_w = {ser_w[134:0], bus.bit1}; ser_n++; end
            if (int'(track_length) > max_len) max_len = int'(track_length);
`ifdef CB_WAIT_CYCLE_EN
            if (bus.curr_index != prev_idx && !bus.wait_cycle) wait_bad = 1;
`else
            if (bus.wait_cycle) wait_bad = 1;
`endif
            prev_idx = bus.curr_index;
            if (bus.write_finish) begin
                if (got < exp_q.size()) begin
                    e = exp_q[got];
                    ew = (136'(e.ch) << e.len) | 136'(e.path);
                    $display("%s emit %0d: char=%0d len=%0d path=0x%0h", nm, got, char_index, track_length, char_path);
                    check($sformatf("%s/char%0d", nm, got), 136'(char_index), 136'(e.ch));
                    check($sformatf("%s/len%0d", nm, got), 136'(track_length), 136'(e.len));
                    check($sformatf("%s/path%0d", nm, got), 136'(char_path), 136'(e.path));
                    check($sformatf("%s/header%0d", nm, got), 136'(bus.header), 136'({1'b1, e.ch}));
                    check($sformatf("%s/found%0d", nm, got), 136'(char_found), 136'd1);
                    check($sformatf("%s/serial%0d", nm, got), ser_w, ew);
                    check($sformatf("%s/nbits%0d", nm, got), 136'(ser_n), 136'(8 + e.len));
                end
                got++; ser_n = 0; ser_w = '0;
            end
            if (finished == 4'b0101) done = 1;
        end
        exp_max = 0;
        foreach (exp_q[i]) if (exp_q[i].len > exp_max) exp_max = exp_q[i].len;
        check({nm, "/finished"}, 136'(done), 136'd1);
        check({nm, "/count"}, 136'(got), 136'(exp_q.size()));
        check({nm, "/max_len"}, 136'(max_len), 136'(exp_max));
        check({nm, "/wait_cycle"}, 136'(wait_bad), 136'd0);
        repeat (3) @(negedge clk);
        check({nm, "/hold"}, 136'({curr_state, finished}), 136'({3'd4, 4'b0101}));
    endtask

    initial begin
        logic [6:0] root;
        bit hit;
        rst = 1'b1; max_index = 7'd0;
        clear_mem();
        add_vec(0, 67, 'b0, 1);
        add_vec(1, 67, 'b0000, 4); add_vec(1, 66, 'b0001, 4); add_vec(1, 68, 'b0010, 4);
        add_vec(1, 69, 'b0011, 4); add_vec(1, 72, 'b0100, 4); add_vec(1, 73, 'b0101, 4);
        add_vec(1, 65, 'b0110, 4); add_vec(1, 70, 'b0111, 4); add_vec(1, 71, 'b10, 2);
        add_vec(1, 74, 'b11, 2);
        add_vec(2, 88, 'b00, 2); add_vec(2, 89, 'b010, 3); add_vec(2, 65, 'b011, 3);

        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            load_fixed(t, root);
            table_expect(t);
            run_walk($sformatf("table%0d", t), root, 1'b1);
        end

        load_fixed(1, root);
        max_index = root;
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        hit = 0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            if (bus.curr_index == (root >> 1) && curr_state != 3'd5) hit = 1;
        end
        check("midwalk_reached", 136'(hit), 136'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midwalk_reset");
        rst = 1'b0;
        table_expect(1);
        run_walk("midwalk_rewalk", root, 1'b0);

        load_chain(root);
        model_walk(root);
        run_walk("chain30", root, 1'b1);

        for (int r = 0; r < 12; r++) begin
            load_random(root);
            model_walk(root);
            run_walk($sformatf("rand%0d", r), root, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
